// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add multiply sequencer that borrows the execute-stage ALU.
// Produces the low XLEN bits of req_a*req_b, one ADD and one SHIFT cycle per multiplier bit.
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake; req_a multiplicand, req_b multiplier
//   resp_valid/ready    response handshake; resp_data product (low word)
//   alu_own             sequencer owns the ALU this cycle (datapath mux select)
//   alu_in1/in2/op      operands and opcode driven to the ALU while owned
//   alu_out             combinational ALU result, same cycle
module alu_mul_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            alu_own,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_out
);

  localparam int CNT_W = $clog2(ITER);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_NOP = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [CNT_W-1:0] cnt;

  logic last_iter;
  assign last_iter = (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc    <= '0;
            mcand  <= req_a;
            mplier <= req_b;
            cnt    <= '0;
            state  <= ADD;
          end
        end
        ADD: begin
          acc   <= alu_out;
          state <= SHIFT;
        end
        SHIFT: begin
          // ALU performs mcand<<1; multiplier shift stays local
          mcand  <= alu_out;
          mplier <= {1'b0, mplier[XLEN-1:1]};
          cnt    <= cnt + CNT_W'(1);
          state  <= last_iter ? DONE : ADD;
        end
        DONE: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    alu_own    = 1'b0;
    alu_in1    = '0;
    alu_in2    = '0;
    alu_op     = OP_NOP;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
      end
      ADD: begin
        alu_own = 1'b1;
        alu_op  = OP_ADD;
        alu_in1 = acc;
        alu_in2 = mplier[0] ? mcand : '0;
      end
      SHIFT: begin
        alu_own = 1'b1;
        alu_op  = OP_SLL;
        alu_in1 = mcand;
        alu_in2 = XLEN'(1);
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_data  = acc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        alu_own;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_acc  = 0;
  int own_cnt = 0;
  logic rv_q = 1'b0;
  logic [31:0] sb[$];

  alu_mul_seq #(.XLEN(32), .ITER(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .alu_own    (alu_own),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_op     (alu_op),
    .alu_out    (alu_out)
  );

  // reference ALU: add and shift-left-logical are all the sequencer uses
  always_comb begin
    case (alu_op)
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0011: alu_out = alu_in1 << alu_in2[4:0];
      default: alu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // response monitor / scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    if (alu_own) own_cnt++;
    if (resp_valid && !rv_q) chk("latency", 32'(cyc - t_acc), 32'd65);
    rv_q = resp_valid;
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_data", resp_data, e);
        chk("own_cycles", 32'(own_cnt), 32'd64);
      end
    end
  end

  // drive a request into an idle sequencer; returns just after the accepting edge
  task automatic submit(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    p = a * b;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    t_acc = cyc;
    own_cnt = 0;
    sb.push_back(p);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_alu_own"}, {31'd0, alu_own}, 32'd0);
    chk({tag, "_alu_in1"}, alu_in1, 32'd0);
    chk({tag, "_alu_in2"}, alu_in2, 32'd0);
    chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
  endtask

  initial begin
    int busy_hits;
    int hold_ok;
    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("reset");

    // basic 3*5 with first ADD/SHIFT operand checks
    @(posedge clk); #1;
    submit(32'd3, 32'd5);
    @(negedge clk);
    chk("add_op", {28'd0, alu_op}, 32'h2);
    chk("add_in1", alu_in1, 32'd0);
    chk("add_in2", alu_in2, 32'd3);
    chk("add_own", {31'd0, alu_own}, 32'd1);
    @(negedge clk);
    chk("sll_op", {28'd0, alu_op}, 32'h3);
    chk("sll_in1", alu_in1, 32'd3);
    chk("sll_in2", alu_in2, 32'd1);
    wait_resp();
    @(negedge clk);
    chk("idle_after_basic", {31'd0, req_ready}, 32'd1);

    // overflow, signed and zero operands
    @(posedge clk); #1; submit(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_resp();
    submit(32'h0001_0000, 32'h0001_0000); wait_resp();
    submit(32'hFFFF_FFFE, 32'd7); wait_resp();
    submit(32'd0, 32'h1234_5678); wait_resp();
    for (int i = 0; i < 4; i++) begin
      submit($urandom, $urandom);
      wait_resp();
    end

    // back-pressure: hold DONE for 10 cycles
    resp_ready = 1'b0;
    submit(32'd6, 32'd7);
    for (int i = 0; i < 100 && !resp_valid; i++) @(negedge clk);
    hold_ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid && resp_data == 32'd42 && !req_ready) hold_ok++;
    end
    chk("hold_stable_cycles", 32'(hold_ok), 32'd10);
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_resp();
    @(negedge clk);
    chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_idle_resp_valid", {31'd0, resp_valid}, 32'd0);

    // request while busy is ignored
    @(posedge clk); #1;
    submit(32'd2, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    req_a = 32'd9;
    req_b = 32'd9;
    req_valid = 1'b1;
    busy_hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ready) busy_hits++;
    end
    chk("busy_req_ready", 32'(busy_hits), 32'd0);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_resp();
    submit(32'd9, 32'd9); wait_resp();

    // reset in the middle of an operation (cycle T+20)
    submit(32'd5, 32'd5);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    chk_reset_outputs("midrst");
    busy_hits = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_valid) busy_hits++;
    end
    chk("no_resp_after_rst", 32'(busy_hits), 32'd0);
    @(posedge clk); #1;
    submit(32'd4, 32'd4); wait_resp();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that time-shares the combinational ALU to compute the low 32 bits of a 32×32 product by shift-and-add. While busy it drives the ALU operand and opcode inputs and raises an ownership flag so the datapath mux hands the ALU to it. It sits beside the ALU in the execute stage and talks to the issuing logic through a valid/ready request channel and a valid/ready response channel.

## Interface
Parameters:
- XLEN, 32, operand/result width; fixed to ALU width, no other value supported
- ITER, 32, multiplier bits processed; must equal XLEN

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_a  in  32  multiplicand
- req_b  in  32  multiplier
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  32  low 32 bits of a*b
- alu_own  out  1  sequencer owns ALU this cycle (datapath mux select)
- alu_in1  out  32  to ALU in1
- alu_in2  out  32  to ALU in2
- alu_op  out  4  to ALU alu_op
- alu_out  in  32  from ALU out (combinational, same cycle)

## Operation
- Internal registers: acc[31:0], mcand[31:0], mplier[31:0], cnt[4:0], state.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE: req_ready=1. On req_valid: acc<=0, mcand<=req_a, mplier<=req_b, cnt<=0, state<=ADD.
- ADD: alu_op=4'b0010, alu_in1=acc, alu_in2 = mplier[0] ? mcand : 32'd0; acc<=alu_out; state<=SHIFT.
- SHIFT: alu_op=4'b0011, alu_in1=mcand, alu_in2=32'd1; mcand<=alu_out; mplier<=mplier>>1 (internal, zero fill); cnt<=cnt+1; state<=DONE if cnt==31 else ADD.
- DONE: resp_valid=1, resp_data=acc. On resp_ready: state<=IDLE. acc held stable until handshake.
- alu_own=1 exactly in ADD and SHIFT. In IDLE/DONE: alu_in1=0, alu_in2=0, alu_op=4'b0000.
- Arithmetic: all sums modulo 2^32; carries and shifted-out bits discarded. Result identical for signed and unsigned operands (low word only).
- req_valid while not IDLE: ignored (req_ready=0); request is not captured.
- No early termination; zero operands take full latency.

## Timing
- Reset: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0; outputs req_ready=1, resp_valid=0, resp_data=0, alu_own=0, alu_in1=0, alu_in2=0, alu_op=0.
- Reset mid-operation (any state): next cycle IDLE with reset values; in-flight product discarded, no resp_valid.
- Accept on edge ending cycle T (req_valid&req_ready). Cycles T+1..T+64 alternate ADD, SHIFT (32 pairs). resp_valid first high in cycle T+65.
- resp_ready high in first DONE cycle: IDLE at T+66, new request acceptable in T+66. Request-to-request throughput 66 cycles minimum.
- resp_ready low: stay in DONE indefinitely, resp_data constant.
- No combinational path req_valid->req_ready or resp_ready->resp_valid; ALU path alu_in*->alu_out->register is single-cycle.
- cnt wraps nowhere: DONE entered on SHIFT with cnt==31.

## Test plan
- Basic: a=3, b=5, resp_ready=1 -> resp_valid at T+65, resp_data=15, alu_own high for exactly 64 cycles.
- Overflow: a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000001; a=0x00010000, b=0x00010000 -> 0x00000000.
- Signed: a=0xFFFFFFFE (-2), b=7 -> 0xFFFFFFF2; a=0, b=0x12345678 -> 0, still 65-cycle latency.
- Back-pressure: a=6, b=7, hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_data=42 stable throughout, req_ready=0; release -> IDLE next cycle.
- Busy request: assert req_valid with a=9, b=9 during ADD/SHIFT of a=2, b=3 -> ignored, result 6; then resubmitted 9×9 -> 81.
- Reset mid-op: rst=1 one cycle at T+20 -> all outputs at reset values next cycle, no resp_valid; following 4×4 -> 16 with normal latency.
